// File: rtl/hw_thread_scheduler.sv
// Coarse-grained hardware thread scheduler: time-slices fetch between NUM_THREADS contexts,
// drains the backend before a context switch and tracks each thread's resume PC from commits.
module hw_thread_scheduler #(
    parameter int          NUM_THREADS   = 2,
    parameter int          QUANTUM       = 1024,
    parameter logic [31:0] RESET_PC_BASE = 32'h1eceb000,
    parameter logic [31:0] PC_STRIDE     = 32'h0001_0000,
    localparam int         TID_W         = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_THREADS-1:0] thread_active,
    input  logic                   long_stall_req,
    input  logic                   commit_valid,
    input  logic [31:0]            commit_next_pc,
    input  logic                   rob_empty,
    input  logic                   imem_idle,
    output logic                   hardware_scheduler_en,
    output logic                   hardware_scheduler_swap_pc,
    output logic [31:0]            hardware_scheduler_pc,
    output logic [TID_W-1:0]       ctx_id,
    output logic [31:0]            swap_count
);

    localparam int             QW    = $clog2(QUANTUM);
    localparam logic [QW-1:0]  QLAST = QW'(QUANTUM - 1);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        SAVE  = 3'd3,
        SWAP  = 3'd4,
        IDLE  = 3'd5
    } state_t;

    function automatic logic [31:0] boot_pc(input int t);
        return RESET_PC_BASE + PC_STRIDE * 32'(t);
    endfunction

    state_t             state_q, state_d;
    logic [TID_W-1:0]   ctx_id_q, ctx_id_d;
    logic [TID_W-1:0]   next_tid_q, next_tid_d;
    logic [31:0]        swap_count_q, swap_count_d;
    logic [QW-1:0]      qcnt_q, qcnt_d;
    logic [31:0]        resume_pc_q, resume_pc_d;
    logic               idle_pending_q, idle_pending_d;
    logic [31:0]        pc_table_q [NUM_THREADS];
    logic [31:0]        pc_table_d [NUM_THREADS];

    // Active mask rotated so that bit i refers to thread (ctx_id + i) mod N.
    logic [2*NUM_THREADS-1:0] rot;
    logic                     other_found, idle_found, switch_req;
    logic [TID_W-1:0]         other_tid, idle_tid;

    assign rot = {thread_active, thread_active} >> ctx_id_q;

    always_comb begin
        other_found = 1'b0;
        other_tid   = '0;
        idle_found  = 1'b0;
        idle_tid    = '0;
        // Descending loops: the nearest candidate after ctx_id is written last and wins.
        for (int i = NUM_THREADS - 1; i >= 1; i--) begin
            if (rot[i]) begin
                other_found = 1'b1;
                other_tid   = TID_W'((int'(ctx_id_q) + i) % NUM_THREADS);
            end
        end
        for (int i = NUM_THREADS; i >= 1; i--) begin
            if (rot[i]) begin
                idle_found = 1'b1;
                idle_tid   = TID_W'((int'(ctx_id_q) + i) % NUM_THREADS);
            end
        end
    end

    assign switch_req = (qcnt_q == QLAST) | long_stall_req | ~rot[0];

    always_comb begin
        state_d        = state_q;
        ctx_id_d       = ctx_id_q;
        next_tid_d     = next_tid_q;
        swap_count_d   = swap_count_q;
        qcnt_d         = qcnt_q;
        resume_pc_d    = resume_pc_q;
        idle_pending_d = idle_pending_q;
        pc_table_d     = pc_table_q;

        case (state_q)
            BOOT: begin
                next_tid_d = '0;
                state_d    = SWAP;
            end
            RUN: begin
                qcnt_d = qcnt_q + QW'(1);
                if (commit_valid) resume_pc_d = commit_next_pc;
                if (switch_req) begin
                    if (other_found) begin
                        next_tid_d     = other_tid;
                        idle_pending_d = 1'b0;
                        state_d        = DRAIN;
                    end else if (rot[0]) begin
                        qcnt_d = '0;
                    end else begin
                        idle_pending_d = 1'b1;
                        state_d        = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Late retirements still belong to the outgoing context.
                if (commit_valid) resume_pc_d = commit_next_pc;
                if (rob_empty && imem_idle) state_d = SAVE;
            end
            SAVE: begin
                pc_table_d[ctx_id_q] = resume_pc_q;
                if (idle_pending_q || !(|thread_active)) state_d = IDLE;
                else                                     state_d = SWAP;
            end
            SWAP: begin
                ctx_id_d       = next_tid_q;
                swap_count_d   = swap_count_q + 32'd1;
                qcnt_d         = '0;
                resume_pc_d    = pc_table_q[next_tid_q];
                idle_pending_d = 1'b0;
                state_d        = RUN;
            end
            IDLE: begin
                if (idle_found) begin
                    next_tid_d     = idle_tid;
                    idle_pending_d = 1'b0;
                    state_d        = SWAP;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BOOT;
            ctx_id_q       <= '0;
            next_tid_q     <= '0;
            swap_count_q   <= '0;
            qcnt_q         <= '0;
            resume_pc_q    <= boot_pc(0);
            idle_pending_q <= 1'b0;
            for (int t = 0; t < NUM_THREADS; t++) pc_table_q[t] <= boot_pc(t);
        end else begin
            state_q        <= state_d;
            ctx_id_q       <= ctx_id_d;
            next_tid_q     <= next_tid_d;
            swap_count_q   <= swap_count_d;
            qcnt_q         <= qcnt_d;
            resume_pc_q    <= resume_pc_d;
            idle_pending_q <= idle_pending_d;
            for (int t = 0; t < NUM_THREADS; t++) pc_table_q[t] <= pc_table_d[t];
        end
    end

    assign hardware_scheduler_en      = (state_q != RUN);
    assign hardware_scheduler_swap_pc = (state_q == SWAP);
    assign hardware_scheduler_pc      = (state_q == SWAP) ? pc_table_q[next_tid_q] : 32'd0;
    assign ctx_id                     = ctx_id_q;
    assign swap_count                 = swap_count_q;

endmodule

// File: tb/tb_hw_thread_scheduler.sv
// Directed bench for hw_thread_scheduler: boot/first switch from a vector table, then
// hand-written sequences for single-thread expiry, stalled drain, idle and mid-drain reset.
module tb_hw_thread_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  thread_active;
  logic        long_stall_req;
  logic        commit_valid;
  logic [31:0] commit_next_pc;
  logic        rob_empty;
  logic        imem_idle;
  logic        sched_en;
  logic        swap_pc;
  logic [31:0] sched_pc;
  logic        ctx_id;
  logic [31:0] swap_count;

  int checks = 0;
  int errors = 0;
  int illegal_cnt = 0;

  hw_thread_scheduler #(
    .NUM_THREADS  (2),
    .QUANTUM      (8),
    .RESET_PC_BASE(32'h1000),
    .PC_STRIDE    (32'h1000)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .thread_active             (thread_active),
    .long_stall_req            (long_stall_req),
    .commit_valid              (commit_valid),
    .commit_next_pc            (commit_next_pc),
    .rob_empty                 (rob_empty),
    .imem_idle                 (imem_idle),
    .hardware_scheduler_en     (sched_en),
    .hardware_scheduler_swap_pc(swap_pc),
    .hardware_scheduler_pc     (sched_pc),
    .ctx_id                    (ctx_id),
    .swap_count                (swap_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // commits are only legal in RUN (1) or DRAIN (2)
  logic [2:0] dut_state;
  assign dut_state = dut.state_q;
  always @(posedge clk) begin
    if (rst_n && commit_valid && dut_state != 3'd1 && dut_state != 3'd2) begin
      illegal_cnt++;
      $display("FAIL illegal_commit state=%0d", dut_state);
    end
  end

  // driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},   {31'd0, sched_en}, 32'd1);
    chk({tag, "_swap"}, {31'd0, swap_pc},  32'd0);
    chk({tag, "_pc"},   sched_pc,          32'd0);
    chk({tag, "_ctx"},  {31'd0, ctx_id},   32'd0);
    chk({tag, "_cnt"},  swap_count,        32'd0);
  endtask

  // n = edges until swap_pc seen, -1 on timeout
  task automatic wait_swap(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (swap_pc) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_en(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (sched_en) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic        cv;
    logic [31:0] cpc;
    logic        en;
    logic        sw;
    logic [31:0] pc;
    logic        ctx;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[13];

  initial begin
    int n;
    int bad;
    int first_sw;
    logic [31:0] pc_at_sw;

    // inputs applied before edge k, outputs expected after edge k
    vt[0]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h1000, 1'b0, 32'd0};  // SWAP
    vt[1]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'd1};  // RUN q0
    vt[2]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'd1};
    vt[3]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'd1};
    vt[4]  = '{1'b1, 32'h1004, 1'b0, 1'b0, 32'h0,    1'b0, 32'd1};
    vt[5]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'd1};
    vt[6]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'd1};
    vt[7]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'd1};
    vt[8]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'd1};  // RUN q7
    vt[9]  = '{1'b1, 32'h1040, 1'b1, 1'b0, 32'h0,    1'b0, 32'd1};  // DRAIN
    vt[10] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b0, 32'd1};  // SAVE
    vt[11] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 1'b0, 32'd1};  // SWAP
    vt[12] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b1, 32'd2};  // RUN t1

    rst_n          = 1'b0;
    thread_active  = 2'b11;
    long_stall_req = 1'b0;
    commit_valid   = 1'b0;
    commit_next_pc = 32'h0;
    rob_empty      = 1'b1;
    imem_idle      = 1'b1;
    step();
    step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // boot and first quantum expiry
    for (int k = 0; k < 13; k++) begin
      commit_valid   = vt[k].cv;
      commit_next_pc = vt[k].cpc;
      step();
      commit_valid = 1'b0;
      chk($sformatf("tbl%0d_en", k),  {31'd0, sched_en}, {31'd0, vt[k].en});
      chk($sformatf("tbl%0d_sw", k),  {31'd0, swap_pc},  {31'd0, vt[k].sw});
      chk($sformatf("tbl%0d_pc", k),  sched_pc,          vt[k].pc);
      chk($sformatf("tbl%0d_ctx", k), {31'd0, ctx_id},   {31'd0, vt[k].ctx});
      chk($sformatf("tbl%0d_cnt", k), swap_count,        vt[k].cnt);
    end

    // thread 1 runs its quantum; switching back presents thread 0's saved PC
    for (int k = 0; k < 6; k++) step();
    commit_valid   = 1'b1;
    commit_next_pc = 32'h2080;
    step();
    commit_valid = 1'b0;
    wait_swap(10, n);
    chk("back_to_t0_latency", n, 32'd3);
    chk("back_to_t0_pc", sched_pc, 32'h1040);
    step();
    chk("back_to_t0_ctx", {31'd0, ctx_id}, 32'd0);
    chk("back_to_t0_cnt", swap_count, 32'd3);

    // single active thread: expiry keeps running, quantum restarts
    thread_active = 2'b01;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (sched_en || swap_pc || ctx_id) bad++;
    end
    chk("single_thread_no_switch", bad, 32'd0);
    thread_active = 2'b11;  // qcnt is 2 here
    wait_en(12, n);
    chk("qcnt_restart_expiry", n, 32'd6);
    wait_swap(5, n);
    chk("to_t1_latency", n, 32'd2);
    chk("to_t1_pc", sched_pc, 32'h2080);
    step();
    chk("to_t1_ctx", {31'd0, ctx_id}, 32'd1);

    // long stall at qcnt=3 with a 5-cycle drain
    for (int k = 0; k < 3; k++) step();
    long_stall_req = 1'b1;
    rob_empty      = 1'b0;
    bad = 0;
    first_sw = -1;
    pc_at_sw = 32'h0;
    for (int k = 1; k <= 7; k++) begin
      step();
      long_stall_req = 1'b0;
      commit_valid   = (k == 1);
      commit_next_pc = (k == 1) ? 32'h2100 : 32'h0;
      if (k == 5) rob_empty = 1'b1;
      if (!sched_en) bad++;
      if (swap_pc && first_sw < 0) begin
        first_sw = k;
        pc_at_sw = sched_pc;
      end
    end
    commit_valid = 1'b0;
    chk("stall_en_held", bad, 32'd0);
    chk("stall_latency", first_sw, 32'd7);
    chk("stall_swap_pc", pc_at_sw, 32'h1040);
    step();
    chk("stall_ctx", {31'd0, ctx_id}, 32'd0);

    // last active thread deactivated -> IDLE, later revived on thread 1
    thread_active = 2'b01;
    step();
    step();
    thread_active = 2'b00;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (!sched_en || swap_pc) bad++;
    end
    chk("idle_no_pulse", bad, 32'd0);
    thread_active = 2'b10;
    wait_swap(5, n);
    chk("idle_wake_latency", n, 32'd1);
    chk("idle_wake_pc", sched_pc, 32'h2100);
    step();
    chk("idle_wake_ctx", {31'd0, ctx_id}, 32'd1);

    // reset in the middle of a drain after a commit
    thread_active  = 2'b11;
    long_stall_req = 1'b1;
    rob_empty      = 1'b0;
    step();
    long_stall_req = 1'b0;
    commit_valid   = 1'b1;
    commit_next_pc = 32'h2200;
    step();
    commit_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_drain_reset");
    step();
    rob_empty = 1'b1;
    rst_n = 1'b1;
    wait_swap(5, n);
    chk("reboot_latency", n, 32'd1);
    chk("reboot_pc", sched_pc, 32'h1000);
    step();
    chk("reboot_cnt", swap_count, 32'd1);
    chk("reboot_ctx", {31'd0, ctx_id}, 32'd0);
    wait_swap(20, n);
    chk("reboot_t1_latency", n, 32'd10);
    chk("reboot_t1_pc", sched_pc, 32'h2000);

    chk("no_illegal_commit", illegal_cnt, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
